// File: rtl/hc_reduce_n_if.sv
// Frame interface for hc_reduce_n: start/done handshake, hC input bus, y output bus.
// Ports: start, hC_flat (and dx_flat with HC_REDUCE_DSKIP_EN) from the producer; y_flat and done from the reducer.
// The dx_flat skip-term bus exists only when HC_REDUCE_DSKIP_EN is defined.
interface hc_reduce_n_if #(
    parameter int B  = 1,
    parameter int H  = 4,
    parameter int P  = 4,
    parameter int N  = 4,
    parameter int DW = 16
);
    localparam int ROWS = B * H * P;

    logic                   start;
    logic [ROWS*N*DW-1:0]   hC_flat;
    logic [ROWS*DW-1:0]     y_flat;
    logic                   done;

`ifdef HC_REDUCE_DSKIP_EN
    logic [ROWS*DW-1:0]     dx_flat;

    modport master (output start, hC_flat, dx_flat, input y_flat, done);
    modport slave  (input start, hC_flat, dx_flat, output y_flat, done);
`else
    modport master (output start, hC_flat, input y_flat, done);
    modport slave  (input start, hC_flat, output y_flat, done);
`endif
endinterface

// File: rtl/hc_reduce_n.sv
// Purpose: reduce hC[b,h,p,n] over n into y[b,h,p] (FP16), PAR row lanes each with a serial adder.
// Latency: start accepted to done = 1 + GROUPS*(2 + N*(A_LAT+1)) + 1 cycles; no throughput overlap.
// Backpressure: none; start is honoured only in IDLE, inputs must stay stable until done.
// Ports: clk, rst (sync, active-low), bus (hc_reduce_n_if.slave: start, hC_flat, [dx_flat], y_flat, done).
// Option: define HC_REDUCE_DSKIP_EN to seed each accumulator with dx[r] (adds the D*x skip term).

// FP16 adder, round-to-nearest-even, subnormal aware; result emerges A_LAT cycles after valid_in.
module fp16_add_wrapper #(
    parameter int A_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] result
);
    logic [15:0] sum_c;
    logic        a_big, sx, sy;
    logic [4:0]  ex, ey;
    logic [9:0]  fx, fy;
    logic [10:0] mx, my;
    logic [5:0]  ex_e, ey_e, dexp, e_n, e_f;
    logic [4:0]  dsh;
    logic [26:0] shw;
    logic [13:0] mx14, my14, m14;
    logic [14:0] s15;
    logic        ru;
    logic [15:0] rnd;
    logic [14:0] mag;
    logic        a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        sum_c = 16'h0000;
        a_nan = (&a[14:10]) & (|a[9:0]);
        b_nan = (&b[14:10]) & (|b[9:0]);
        a_inf = (&a[14:10]) & ~(|a[9:0]);
        b_inf = (&b[14:10]) & ~(|b[9:0]);

        // x is the operand of larger magnitude so the subtraction never goes negative
        a_big = (a[14:0] >= b[14:0]);
        sx = a_big ? a[15]    : b[15];
        ex = a_big ? a[14:10] : b[14:10];
        fx = a_big ? a[9:0]   : b[9:0];
        sy = a_big ? b[15]    : a[15];
        ey = a_big ? b[14:10] : a[14:10];
        fy = a_big ? b[9:0]   : a[9:0];

        mx   = {(ex != 5'd0), fx};
        my   = {(ey != 5'd0), fy};
        ex_e = (ex == 5'd0) ? 6'd1 : {1'b0, ex};
        ey_e = (ey == 5'd0) ? 6'd1 : {1'b0, ey};
        dexp = ex_e - ey_e;
        dsh  = (dexp > 6'd27) ? 5'd27 : dexp[4:0];

        // Align y with guard, round and sticky bits; everything shifted past them folds into sticky.
        shw  = {my, 16'd0} >> dsh;
        my14 = {shw[26:14], |shw[13:0]};
        mx14 = {mx, 3'b000};

        if (sx == sy) s15 = {1'b0, mx14} + {1'b0, my14};
        else          s15 = {1'b0, mx14} - {1'b0, my14};

        e_n = ex_e;
        if (s15[14]) begin
            m14 = {s15[14:2], s15[1] | s15[0]};
            e_n = e_n + 6'd1;
        end else begin
            m14 = s15[13:0];
            // Left-normalise, stopping at the subnormal exponent
            for (int k = 0; k < 13; k++) begin
                if (!m14[13] && (e_n > 6'd1)) begin
                    m14 = {m14[12:0], 1'b0};
                    e_n = e_n - 6'd1;
                end
            end
        end

        e_f = m14[13] ? e_n : 6'd0;
        ru  = m14[2] & (m14[3] | m14[1] | m14[0]);
        // Rounding carry ripples from fraction into exponent, covering subnormal->normal and overflow->inf
        rnd = {e_f, m14[12:3]} + {15'd0, ru};
        mag = (rnd >= 16'h7C00) ? 15'h7C00 : rnd[14:0];

        if (s15 == 15'd0) sum_c = {sx & sy, 15'd0};
        else              sum_c = {sx, mag};

        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) sum_c = 16'h7E00;
        else if (a_inf) sum_c = a;
        else if (b_inf) sum_c = b;
    end

    logic [A_LAT-1:0] vld_pipe;
    logic [15:0]      dat_pipe [A_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= valid_in;
            for (int k = 1; k < A_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        dat_pipe[0] <= sum_c;
        for (int k = 1; k < A_LAT; k++) dat_pipe[k] <= dat_pipe[k-1];
    end

    assign valid_out = vld_pipe[A_LAT-1];
    assign result    = dat_pipe[A_LAT-1];
endmodule

module hc_reduce_n #(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int A_LAT = 6,
    parameter int PAR   = 4
) (
    input  logic         clk,
    input  logic         rst,
    hc_reduce_n_if.slave bus
);
    localparam int ROWS   = B * H * P;
    localparam int GROUPS = (ROWS + PAR - 1) / PAR;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int NW     = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         state;
    logic [GW-1:0]      grp;
    logic [NW-1:0]      n_cnt;
    logic [DW-1:0]      acc      [PAR];
    logic [ROWS*DW-1:0] y_q;
    logic               done_q;

    logic               add_vld_in;
    logic [PAR-1:0]     add_vld_out;
    logic [DW-1:0]      add_b    [PAR];
    logic [DW-1:0]      add_res  [PAR];
    logic [DW-1:0]      init_val [PAR];
    logic               lane_ok  [PAR];
    int                 lane_row [PAR];
    int                 sel_row  [PAR];

    // Lanes past the last row still run (keeps all adders in lockstep) on row 0's data, but never store.
    always_comb begin
        for (int i = 0; i < PAR; i++) begin
            lane_row[i] = int'(grp) * PAR + i;
            lane_ok[i]  = (lane_row[i] < ROWS);
            sel_row[i]  = lane_ok[i] ? lane_row[i] : 0;
            add_b[i]    = bus.hC_flat[(sel_row[i] * N + int'(n_cnt)) * DW +: DW];
`ifdef HC_REDUCE_DSKIP_EN
            init_val[i] = bus.dx_flat[sel_row[i] * DW +: DW];
`else
            init_val[i] = '0;
`endif
        end
    end

    assign add_vld_in = (state == S_ISSUE);

    for (genvar i = 0; i < PAR; i++) begin : g_lane
        fp16_add_wrapper #(.A_LAT(A_LAT)) u_add (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (add_vld_in),
            .a         (acc[i]),
            .b         (add_b[i]),
            .valid_out (add_vld_out[i]),
            .result    (add_res[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            grp    <= '0;
            n_cnt  <= '0;
            done_q <= 1'b0;
            y_q    <= '0;
            for (int i = 0; i < PAR; i++) acc[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    grp <= '0;
                    if (bus.start) state <= S_INIT;
                end
                S_INIT: begin
                    for (int i = 0; i < PAR; i++) acc[i] <= init_val[i];
                    n_cnt <= '0;
                    state <= S_ISSUE;
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // All lanes issue together, so they complete together.
                    if (&add_vld_out) begin
                        for (int i = 0; i < PAR; i++) acc[i] <= add_res[i];
                        if (n_cnt == NW'(N - 1)) begin
                            state <= S_STORE;
                        end else begin
                            n_cnt <= n_cnt + NW'(1);
                            state <= S_ISSUE;
                        end
                    end
                end
                S_STORE: begin
                    for (int i = 0; i < PAR; i++) begin
                        if (lane_ok[i]) y_q[sel_row[i] * DW +: DW] <= acc[i];
                    end
                    if (grp == GW'(GROUPS - 1)) begin
                        grp    <= '0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        grp   <= grp + GW'(1);
                        state <= S_INIT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.y_flat = y_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_hc_reduce_n.sv
// Bench for hc_reduce_n: two instances (PAR=4 and PAR=3) share stimulus; a real-arithmetic FP16 model
// produces expected rows that monitors pop and compare on each done pulse.
module tb_hc_reduce_n;
    localparam int B = 1, H = 4, P = 4, N = 4, DW = 16, A_LAT = 6;
    localparam int ROWS = B * H * P;
    localparam int T0 = 1 + ((ROWS + 3) / 4) * (2 + N * (A_LAT + 1)) + 1;  // 122
    localparam int T3 = 1 + ((ROWS + 2) / 3) * (2 + N * (A_LAT + 1)) + 1;  // 182

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [ROWS*N*DW-1:0] hc_v = '0;
`ifdef HC_REDUCE_DSKIP_EN
    logic [ROWS*DW-1:0] dx_v = '0;
`endif

    always #5 clk = ~clk;

    hc_reduce_n_if #(.B(B), .H(H), .P(P), .N(N), .DW(DW)) bus0 ();
    hc_reduce_n_if #(.B(B), .H(H), .P(P), .N(N), .DW(DW)) bus3 ();

    assign bus0.start   = start;
    assign bus3.start   = start;
    assign bus0.hC_flat = hc_v;
    assign bus3.hC_flat = hc_v;
`ifdef HC_REDUCE_DSKIP_EN
    assign bus0.dx_flat = dx_v;
    assign bus3.dx_flat = dx_v;
`endif

    hc_reduce_n #(.B(B), .H(H), .P(P), .N(N), .DW(DW), .A_LAT(A_LAT), .PAR(4)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    hc_reduce_n #(.B(B), .H(H), .P(P), .N(N), .DW(DW), .A_LAT(A_LAT), .PAR(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt0 = 0;
    int done_cnt3 = 0;
    logic [ROWS*DW-1:0] exp_q0[$];
    logic [ROWS*DW-1:0] exp_q3[$];
    logic [ROWS*DW-1:0] e0, e3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    function automatic real to_r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) v = real'(h[9:0]) * (2.0 ** -24.0);
        else v = real'({1'b1, h[9:0]}) * (2.0 ** (real'(h[14:10]) - 25.0));
        return h[15] ? -v : v;
    endfunction

    // Round an exactly representable double to FP16, nearest-even.
    function automatic logic [15:0] to_h(input real v);
        logic [63:0] bits, m, q, rem, half, mag;
        int e, k;
        bits = $realtobits(v);
        if (bits[62:0] == 63'd0) return {bits[63], 15'd0};
        e = int'(bits[62:52]) - 1023;
        m = {11'd0, 1'b1, bits[51:0]};
        k = (e >= -14) ? 42 : 28 - e;
        q = m >> k;
        rem = m - (q << k);
        half = 64'd1 << (k - 1);
        if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
        mag = (e >= -14) ? ((64'(e + 14) << 10) + q) : q;
        if (mag >= 64'h7C00) mag = 64'h7C00;
        return {bits[63], mag[14:0]};
    endfunction

    function automatic logic [ROWS*DW-1:0] model();
        logic [ROWS*DW-1:0] y;
        logic [15:0] acc;
        for (int r = 0; r < ROWS; r++) begin
`ifdef HC_REDUCE_DSKIP_EN
            acc = dx_v[r*DW +: DW];
`else
            acc = 16'h0000;
`endif
            for (int n = 0; n < N; n++)
                acc = to_h(to_r(acc) + to_r(hc_v[(r*N+n)*DW +: DW]));
            y[r*DW +: DW] = acc;
        end
        return y;
    endfunction

    function automatic logic [15:0] rnd_h();
        logic [15:0] v;
        v[15] = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(0, 20));
        v[9:0] = 10'($urandom);
        return v;
    endfunction

    task automatic rand_fill();
        for (int g = 0; g < ROWS * N; g++) begin
            if ((g % 2 == 1) && ($urandom_range(0, 3) == 0))
                hc_v[g*DW +: DW] = hc_v[(g-1)*DW +: DW] ^ 16'h8000;
            else
                hc_v[g*DW +: DW] = rnd_h();
        end
`ifdef HC_REDUCE_DSKIP_EN
        for (int r = 0; r < ROWS; r++) dx_v[r*DW +: DW] = rnd_h();
`endif
    endtask

    always @(negedge clk) begin
        if (rst && bus0.done) begin
            done_cnt0++;
            if (exp_q0.size() == 0) fail("spurious_done0");
            else begin
                e0 = exp_q0.pop_front();
                for (int r = 0; r < ROWS; r++)
                    chk($sformatf("par4_y[%0d]", r), int'(bus0.y_flat[r*DW +: DW]), int'(e0[r*DW +: DW]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus3.done) begin
            done_cnt3++;
            if (exp_q3.size() == 0) fail("spurious_done3");
            else begin
                e3 = exp_q3.pop_front();
                for (int r = 0; r < ROWS; r++)
                    chk($sformatf("par3_y[%0d]", r), int'(bus3.y_flat[r*DW +: DW]), int'(e3[r*DW +: DW]));
            end
        end
    end

    // One frame on both instances; latency is counted from the edge that samples start.
    // done first shows after edge st+T-2 (T also counts the IDLE and DONE cycles).
    task automatic run_frame(input bit repulse);
        logic [ROWS*DW-1:0] e;
        int st, d0, d3, c0, c3;
        bit s0, s3;
        e = model();
        exp_q0.push_back(e);
        exp_q3.push_back(e);
        c0 = done_cnt0; c3 = done_cnt3;
        s0 = 0; s3 = 0; d0 = 0; d3 = 0;
        @(negedge clk); start = 1'b1; st = cyc + 1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 400 && !(s0 && s3); k++) begin
            @(negedge clk);
            if (repulse && k == 50) start = 1'b1;
            if (repulse && k == 52) start = 1'b0;
            if (bus0.done && !s0) begin s0 = 1; d0 = cyc; end
            if (bus3.done && !s3) begin s3 = 1; d3 = cyc; end
        end
        if (!s0) fail("timeout_done0"); else chk("latency_par4", d0 - st + 2, T0);
        if (!s3) fail("timeout_done3"); else chk("latency_par3", d3 - st + 2, T3);
        repeat (5) @(negedge clk);
        chk("done_count_par4", done_cnt0 - c0, 1);
        chk("done_count_par3", done_cnt3 - c3, 1);
    endtask

    initial begin
        logic [ROWS*DW-1:0] e;
        int st, d0a, d0b, n0, n3, c0, c3;

        repeat (3) @(negedge clk);
        chk("reset_y_par4", int'(|bus0.y_flat), 0);
        chk("reset_y_par3", int'(|bus3.y_flat), 0);
        chk("reset_done", int'(bus0.done | bus3.done), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All ones: each row sums to 4.0 (4.5 with a 0.5 skip term)
        for (int g = 0; g < ROWS * N; g++) hc_v[g*DW +: DW] = 16'h3C00;
`ifdef HC_REDUCE_DSKIP_EN
        for (int r = 0; r < ROWS; r++) dx_v[r*DW +: DW] = 16'h3800;
        run_frame(1'b0);
        chk("ones_row0", int'(bus0.y_flat[15:0]), 16'h4480);
        dx_v = '0;
`else
        run_frame(1'b0);
        chk("ones_row0", int'(bus0.y_flat[15:0]), 16'h4400);
`endif

        // Row 0 = {1, 2, -1, 0.5}, rest zero
        hc_v = '0;
        hc_v[63:0] = {16'h3800, 16'hBC00, 16'h4000, 16'h3C00};
        run_frame(1'b0);
        chk("row0_mix", int'(bus0.y_flat[15:0]), 16'h4100);
        chk("row15_zero_par3", int'(bus3.y_flat[ROWS*DW-1 -: DW]), 16'h0000);

        // Exact cancellation in row 5, start re-pulsed while busy
        rand_fill();
        hc_v[5*N*DW +: 4*DW] = {16'hBC00, 16'h3C00, 16'hC200, 16'h4200};
`ifdef HC_REDUCE_DSKIP_EN
        dx_v[5*DW +: DW] = 16'h0000;
`endif
        run_frame(1'b1);
        chk("cancel_row5", int'(bus0.y_flat[5*DW +: DW]), 16'h0000);

        for (int f = 0; f < 4; f++) begin
            rand_fill();
            run_frame(1'b0);
        end

        // Reset in the WAIT phase of group 2 (PAR=4); that frame is abandoned
        rand_fill();
        e = model();
        exp_q0.push_back(e);
        exp_q3.push_back(e);
        c0 = done_cnt0; c3 = done_cnt3;
        @(negedge clk); start = 1'b1; st = cyc + 1;
        @(negedge clk); start = 1'b0;
        while (cyc < st + 64) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_y_par4", int'(|bus0.y_flat), 0);
        chk("midreset_y_par3", int'(|bus3.y_flat), 0);
        chk("midreset_done", int'(bus0.done | bus3.done), 0);
        void'(exp_q0.pop_back());
        void'(exp_q3.pop_back());
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_done_after_reset0", done_cnt0 - c0, 0);
        chk("no_done_after_reset3", done_cnt3 - c3, 0);
        run_frame(1'b0);

        // start held: PAR=4 relaunches once after DONE, PAR=3 sees start low at its DONE
        rand_fill();
        e = model();
        exp_q0.push_back(e);
        exp_q0.push_back(e);
        exp_q3.push_back(e);
        c0 = done_cnt0; c3 = done_cnt3;
        n0 = 0; n3 = 0; d0a = 0; d0b = 0;
        @(negedge clk); start = 1'b1; st = cyc + 1;
        for (int k = 0; k < 600 && !(n0 == 2 && n3 == 1); k++) begin
            @(negedge clk);
            if (bus0.done) begin
                if (n0 == 0) d0a = cyc; else d0b = cyc;
                n0++;
            end
            if (bus3.done) n3++;
            if (n0 == 1 && cyc == d0a + 2) start = 1'b0;
        end
        start = 1'b0;
        if (n0 < 2) fail("timeout_b2b_par4");
        else begin
            chk("b2b_first_latency", d0a - st + 2, T0);
            chk("b2b_gap", d0b - d0a, T0);
        end
        if (n3 < 1) fail("timeout_b2b_par3");
        repeat (5) @(negedge clk);
        chk("b2b_done_count_par4", done_cnt0 - c0, 2);
        chk("b2b_done_count_par3", done_cnt3 - c3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
